// File: rtl/regfile_mp.sv
// Multi-port register file: NREAD combinational read ports with write/link bypass,
// one merged-mode write port, a link port for jal and a per-register load-busy scoreboard.
module regfile_mp #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int AW       = $clog2(DEPTH),
  parameter int NREAD    = 2,
  parameter int LINK_REG = DEPTH - 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREAD*AW-1:0]    rd_addr,
  output logic [NREAD*WIDTH-1:0] rd_data,
  output logic [NREAD-1:0]       rd_busy,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [1:0]             wr_mode,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   link_en,
  input  logic [WIDTH-1:0]       link_data,
  input  logic                   mark_en,
  input  logic [AW-1:0]          mark_addr,
  output logic                   collide
);

  localparam logic [AW-1:0] LINK_A = AW'(LINK_REG);

  logic [DEPTH-1:0][WIDTH-1:0] regs;
  logic [DEPTH-1:0]            busy;
  logic [DEPTH-1:0]            clear;
  logic [DEPTH-1:0]            set;
  logic [WIDTH-1:0]            old;
  logic [WIDTH-1:0]            merged;
  logic                        eff_wr;
  logic                        link_hit;

  assign link_hit = link_en && (wr_addr == LINK_A);
  assign eff_wr   = wr_en && (wr_addr != '0) && !link_hit;
  assign old      = regs[wr_addr];

  always_comb begin
    merged = wr_data;
    case (wr_mode)
      2'b01:   merged = {old[WIDTH-1:8], wr_data[7:0]};
      2'b10:   merged = {old[WIDTH-1:WIDTH/2], wr_data[WIDTH/2-1:0]};
      2'b11:   merged = {wr_data[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      default: merged = wr_data;
    endcase
  end

  // Anything that retires a value into a register clears its busy bit.
  always_comb begin
    clear = '0;
    set   = '0;
    if (eff_wr)                       clear[wr_addr]   = 1'b1;
    if (link_en)                      clear[LINK_A]    = 1'b1;
    if (mark_en && mark_addr != '0)   set[mark_addr]   = 1'b1;
  end

  // Reads are forced to zero while reset is held so in-flight strobes cannot leak through bypass.
  for (genvar g = 0; g < NREAD; g++) begin : g_rd
    logic [AW-1:0] a;
    assign a = rd_addr[g*AW +: AW];
    assign rd_data[g*WIDTH +: WIDTH] =
      (rst || a == '0)             ? '0 :
      (link_en && a == LINK_A)     ? link_data :
      (eff_wr && wr_addr == a)     ? merged :
                                     regs[a];
    assign rd_busy[g] = !rst && busy[a] && !clear[a];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs    <= '0;
      busy    <= '0;
      collide <= 1'b0;
    end else begin
      if (eff_wr)  regs[wr_addr] <= merged;
      if (link_en) regs[LINK_A]  <= link_data;
      busy    <= (busy & ~clear) | set;
      collide <= link_hit && wr_en;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: default 2-port instance plus a 16x16, 4-port instance.
module tb_regfile_mp;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: defaults (WIDTH 32, DEPTH 32, NREAD 2)
  logic [9:0]  a_rd_addr = '0;
  logic [63:0] a_rd_data;
  logic [1:0]  a_rd_busy;
  logic        a_wr_en = 0;
  logic [4:0]  a_wr_addr = '0;
  logic [1:0]  a_wr_mode = '0;
  logic [31:0] a_wr_data = '0;
  logic        a_link_en = 0;
  logic [31:0] a_link_data = '0;
  logic        a_mark_en = 0;
  logic [4:0]  a_mark_addr = '0;
  logic        a_collide;

  // Instance B: WIDTH 16, DEPTH 16, NREAD 4
  logic [15:0] b_rd_addr = '0;
  logic [63:0] b_rd_data;
  logic [3:0]  b_rd_busy;
  logic        b_wr_en = 0;
  logic [3:0]  b_wr_addr = '0;
  logic [1:0]  b_wr_mode = '0;
  logic [15:0] b_wr_data = '0;
  logic        b_link_en = 0;
  logic [15:0] b_link_data = '0;
  logic        b_mark_en = 0;
  logic [3:0]  b_mark_addr = '0;
  logic        b_collide;

  regfile_mp dut_a (
    .clk(clk), .rst(rst), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_mode(a_wr_mode), .wr_data(a_wr_data),
    .link_en(a_link_en), .link_data(a_link_data), .mark_en(a_mark_en),
    .mark_addr(a_mark_addr), .collide(a_collide)
  );

  regfile_mp #(.WIDTH(16), .DEPTH(16), .NREAD(4)) dut_b (
    .clk(clk), .rst(rst), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_mode(b_wr_mode), .wr_data(b_wr_data),
    .link_en(b_link_en), .link_data(b_link_data), .mark_en(b_mark_en),
    .mark_addr(b_mark_addr), .collide(b_collide)
  );

  typedef struct {
    string       name;
    int          inst;   // 0 = A, 1 = B
    int          kind;   // 0 = rd_data, 1 = rd_busy, 2 = collide
    int          port;
    logic [31:0] exp;
  } item_t;

  item_t q[$];
  int checks = 0;
  int errors = 0;
  bit done = 1'b0;

  function automatic void exp_d(string n, int inst, int port, logic [31:0] v);
    item_t it;
    it.name = n; it.inst = inst; it.kind = 0; it.port = port; it.exp = v;
    q.push_back(it);
  endfunction

  function automatic void exp_b(string n, int inst, int port, logic v);
    item_t it;
    it.name = n; it.inst = inst; it.kind = 1; it.port = port; it.exp = {31'd0, v};
    q.push_back(it);
  endfunction

  function automatic void exp_c(string n, int inst, logic v);
    item_t it;
    it.name = n; it.inst = inst; it.kind = 2; it.port = 0; it.exp = {31'd0, v};
    q.push_back(it);
  endfunction

  // Monitor: outputs are combinational, so every queued expectation is compared mid-cycle.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      item_t it;
      logic [31:0] act;
      it  = q.pop_front();
      act = '0;
      case (it.kind)
        0: act = (it.inst == 0) ? a_rd_data[it.port*32 +: 32] : {16'd0, b_rd_data[it.port*16 +: 16]};
        1: act = (it.inst == 0) ? {31'd0, a_rd_busy[it.port]} : {31'd0, b_rd_busy[it.port]};
        default: act = (it.inst == 0) ? {31'd0, a_collide} : {31'd0, b_collide};
      endcase
      checks++;
      if (act !== it.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", it.name, act, it.exp);
      end
    end
  end

  // Watchdog: the stimulus must complete within a bounded number of cycles.
  initial begin
    repeat (200) @(posedge clk);
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL timeout: stimulus did not complete within 200 cycles");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  task automatic a_idle();
    a_wr_en = 0; a_link_en = 0; a_mark_en = 0;
  endtask

  task automatic a_wr(input logic [4:0] addr, input logic [1:0] mode, input logic [31:0] d);
    a_wr_en = 1; a_wr_addr = addr; a_wr_mode = mode; a_wr_data = d;
  endtask

  task automatic a_ra(input logic [4:0] p0, input logic [4:0] p1);
    a_rd_addr = {p1, p0};
  endtask

  task automatic next();
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset state
    next();
    a_ra(5'd1, 5'd31);
    #1;
    checks++;
    if (a_rd_data !== '0 || a_rd_busy !== '0 || a_collide !== 1'b0 ||
        b_rd_data !== '0 || b_rd_busy !== '0 || b_collide !== 1'b0) begin
      errors++;
      $display("FAIL rst_direct: a_d=%h a_b=%b a_c=%b b_d=%h b_b=%b b_c=%b",
               a_rd_data, a_rd_busy, a_collide, b_rd_data, b_rd_busy, b_collide);
    end
    exp_d("rst_d0", 0, 0, 0); exp_d("rst_d1", 0, 1, 0);
    exp_b("rst_b0", 0, 0, 0); exp_c("rst_col", 0, 0);
    exp_c("rst_col_b", 1, 0);

    // r5 write + mark in the same cycle: busy set wins
    next(); rst = 0;
    a_wr(5'd5, 2'b00, 32'hDEADBEEF); a_mark_en = 1; a_mark_addr = 5'd5; a_ra(5'd5, 5'd5);
    exp_d("r5_byp", 0, 0, 32'hDEADBEEF); exp_b("r5_byp_busy", 0, 0, 0);
    next(); a_idle();
    exp_d("r5_st0", 0, 0, 32'hDEADBEEF); exp_d("r5_st1", 0, 1, 32'hDEADBEEF);
    exp_b("r5_busy", 0, 1, 1);
    // Mid-cycle reset with a write still presented
    @(posedge clk); #2;
    rst = 1; a_wr(5'd5, 2'b00, 32'h00000001); a_mark_en = 1;
    exp_d("midrst_d0", 0, 0, 0); exp_d("midrst_d1", 0, 1, 0);
    exp_b("midrst_b0", 0, 0, 0); exp_b("midrst_b1", 0, 1, 0); exp_c("midrst_col", 0, 0);
    next(); rst = 0; a_idle();
    exp_d("post_rst_r5", 0, 0, 0); exp_b("post_rst_busy", 0, 0, 0);

    // Write modes on r3, back to back
    next(); a_wr(5'd3, 2'b00, 32'h12345678); a_ra(5'd3, 5'd3);
    exp_d("full", 0, 0, 32'h12345678);
    next(); a_wr(5'd3, 2'b01, 32'hFFFFFFAB);
    exp_d("byte", 0, 0, 32'h123456AB);
    next(); a_wr(5'd3, 2'b10, 32'hFFFFCDEF);
    exp_d("half", 0, 0, 32'h1234CDEF);
    next(); a_wr(5'd3, 2'b11, 32'h0000BEEF);
    exp_d("upper", 0, 0, 32'hBEEF0000);
    next(); a_idle();
    exp_d("upper_st0", 0, 0, 32'hBEEF0000); exp_d("upper_st1", 0, 1, 32'hBEEF0000);

    // Bypass and r0
    next(); a_wr(5'd7, 2'b00, 32'hCAFEF00D); a_ra(5'd7, 5'd0);
    exp_d("byp_r7", 0, 0, 32'hCAFEF00D); exp_d("byp_r0", 0, 1, 0);
    next(); a_wr(5'd0, 2'b00, 32'hFFFFFFFF); a_ra(5'd0, 5'd7);
    exp_d("wr_r0_byp", 0, 0, 0); exp_d("r7_st", 0, 1, 32'hCAFEF00D);
    next(); a_idle();
    exp_d("r0_st", 0, 0, 0);

    // Link collision on r31
    next(); a_wr(5'd31, 2'b00, 32'h11111111); a_link_en = 1; a_link_data = 32'h00400010;
    a_ra(5'd31, 5'd31);
    exp_d("link_byp", 0, 0, 32'h00400010); exp_c("col_pre", 0, 0);
    next(); a_idle();
    exp_d("link_st", 0, 1, 32'h00400010); exp_c("col_pulse", 0, 1);
    next();
    exp_c("col_end", 0, 0);

    // Scoreboard on r9
    next(); a_mark_en = 1; a_mark_addr = 5'd9; a_ra(5'd9, 5'd0);
    exp_b("mark_same", 0, 0, 0);
    next(); a_idle();
    exp_b("mark_next", 0, 0, 1);
    next(); a_wr(5'd9, 2'b00, 32'h00000099); a_mark_en = 1; a_mark_addr = 5'd9;
    exp_b("wr_mark_byp", 0, 0, 0); exp_d("wr_mark_d", 0, 0, 32'h00000099);
    next(); a_idle();
    exp_b("set_wins", 0, 0, 1);
    next(); a_wr(5'd9, 2'b00, 32'h0000005A);
    exp_b("clr_byp", 0, 0, 0); exp_d("clr_d", 0, 0, 32'h0000005A);
    next(); a_idle(); a_mark_en = 1; a_mark_addr = 5'd0;
    exp_b("clr_st", 0, 0, 0);
    next(); a_idle(); a_ra(5'd9, 5'd0);
    exp_b("r0_mark", 0, 1, 0);

    // Parameter variant: LINK_REG = 15, 16-bit upper mode, four independent ports
    next(); b_link_en = 1; b_link_data = 16'h1234;
    b_wr_en = 1; b_wr_addr = 4'd2; b_wr_mode = 2'b11; b_wr_data = 16'hABCD;
    b_rd_addr = {4'd0, 4'd0, 4'd2, 4'd15};
    exp_d("b_link", 1, 0, 32'h1234); exp_d("b_upper", 1, 1, 32'hCD00); exp_d("b_p2", 1, 2, 0);
    next(); b_link_en = 0; b_wr_addr = 4'd4; b_wr_mode = 2'b00; b_wr_data = 16'h4444;
    b_rd_addr = {4'd0, 4'd4, 4'd2, 4'd15};
    exp_d("b_p0", 1, 0, 32'h1234); exp_d("b_p1", 1, 1, 32'hCD00);
    exp_d("b_p2w", 1, 2, 32'h4444); exp_d("b_p3", 1, 3, 0);
    next(); b_wr_addr = 4'd2; b_wr_mode = 2'b01; b_wr_data = 16'h0077;
    b_rd_addr = {4'd2, 4'd15, 4'd4, 4'd2};
    exp_d("b_byte0", 1, 0, 32'hCD77); exp_d("b_p1r4", 1, 1, 32'h4444);
    exp_d("b_p2r15", 1, 2, 32'h1234); exp_d("b_byte3", 1, 3, 32'hCD77);
    next(); b_wr_en = 0; b_rd_addr = {4'd1, 4'd15, 4'd2, 4'd4};
    exp_d("b_st0", 1, 0, 32'h4444); exp_d("b_st1", 1, 1, 32'hCD77);
    exp_d("b_st2", 1, 2, 32'h1234); exp_d("b_st3", 1, 3, 0);
    exp_c("b_col", 1, 0);

    @(negedge clk); @(negedge clk);
    done = 1'b1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending: %0d expectations never compared", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the MIPS_32 datapath, and the successor to the current single-read-pair register file. It provides NREAD combinational read ports with write-to-read bypass and one write port supporting full, byte, halfword and load-upper write modes. It also has a dedicated link-register port for jal, and a per-register busy scoreboard for in-flight loads. It sits between decode (read ports, busy marking) and writeback (write/link ports).

## Interface
- WIDTH, 32: register width; even, >= 16.
- DEPTH, 32: number of registers; power of two, >= 4.
- AW, log2(DEPTH): register address width.
- NREAD, 2: number of read ports, 1..4.
- LINK_REG, DEPTH-1: index written by the link port.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- rd_addr  in  NREAD*AW  read addresses; port i at [i*AW +: AW].
- rd_data  out  NREAD*WIDTH  read data; port i at [i*WIDTH +: WIDTH].
- rd_busy  out  NREAD  port i register awaiting a load writeback.
- wr_en  in  1  writeback strobe.
- wr_addr  in  AW  writeback destination.
- wr_mode  in  2  00 full, 01 byte, 10 half, 11 upper.
- wr_data  in  WIDTH  writeback data.
- link_en  in  1  link write strobe (jal).
- link_data  in  WIDTH  return address (pc+4, computed upstream).
- mark_en  in  1  set busy on mark_addr (load issued).
- mark_addr  in  AW  register to mark busy.
- collide  out  1  registered pulse: writeback dropped by link collision.

## Operation
- Register 0 reads as 0, ignores all writes (wr, link), and never becomes busy; mark_en to 0 is ignored.
- Merged write value M for register r with old value R:
  - mode 00: M = wr_data.
  - mode 01: M = {R[WIDTH-1:8], wr_data[7:0]}.
  - mode 10: M = {R[WIDTH-1:WIDTH/2], wr_data[WIDTH/2-1:0]}.
  - mode 11: M = {wr_data[WIDTH/2-1:0], WIDTH/2 zeros}.
- Effective write: wr_en && wr_addr != 0 && !(link_en && wr_addr == LINK_REG).
- Link write: link_en writes link_data to LINK_REG.
- Collision: if link_en and wr_en both target LINK_REG, link wins, the writeback is dropped, and collide is 1 the next cycle for exactly one cycle.
- Read bypass is checked in priority order per port:
  - addr 0 reads 0.
  - Else, if link_en and addr == LINK_REG, reads link_data.
  - Else, if an effective write targets addr, reads M.
  - Else reads the stored value.
- Busy scoreboard, one bit per register:
  - An effective write or link write to r clears busy[r].
  - mark_en sets busy[mark_addr].
  - If mark and clear hit the same register in the same cycle, set wins.
- rd_busy[i] = busy[addr_i] && !(a clear hits addr_i this cycle). A bypassed value is therefore never reported busy.
- The old block's readmemb/writememb file I/O is removed; initial state comes from reset only.

## Timing
- Reads: combinational from rd_addr/wr_*/link_* to rd_data/rd_busy, zero latency.
- Writes, link, mark: take effect at the rising clk edge and are visible in the stored value the following cycle.
- collide: registered, asserted the cycle after the collision, 1 cycle wide.
- Reset, asynchronous and effective immediately while rst is high, even mid-cycle or mid-write:
  - all registers = 0, all busy = 0, collide = 0.
  - Therefore rd_data = 0 and rd_busy = 0 on every port.
  - Writes, links and marks presented while rst is high are discarded.
- On the first rising edge after rst deasserts, normal writes apply.
- Back-to-back writes to the same register: each cycle's merge uses the value stored at the previous edge. A byte write following a full write in consecutive cycles merges with the full-write value.
- Simultaneous reads of the same address on several ports return identical data.

## Test plan
- Reset: assert rst mid-cycle after writing r5 = 0xDEADBEEF and marking r5 -> rd_data on all ports = 0 immediately, rd_busy = 0, collide = 0; after release r5 reads 0.
- Write modes: r3 = 0x12345678; byte write 0xAB -> 0x123456AB; half write 0xCDEF -> 0x1234CDEF; upper write 0x0000BEEF -> 0xBEEF0000.
- Bypass: wr_en r7 full 0xCAFEF00D with rd_addr port0 = 7, port1 = 0 in the same cycle -> port0 = 0xCAFEF00D combinationally, port1 = 0; a write to r0 leaves r0 reading 0.
- Link collision: link_en with link_data 0x00400010 and wr_en r31 = 0x11111111 in the same cycle -> r31 reads 0x00400010 (bypass and stored), collide = 1 for exactly the next cycle.
- Scoreboard: mark r9 -> rd_busy = 1 from the next cycle. Writeback r9 with mark r9 in the same cycle -> busy stays 1. Writeback r9 alone -> rd_busy = 0 in that cycle via bypass, and stays 0 after the edge.
- Parameters: NREAD = 4, DEPTH = 16, WIDTH = 16 -> LINK_REG = 15, upper mode gives {wr_data[7:0], 8'h00}, and all four ports read independently.
